hdmi_timing_gen: RTL and testbench

HDMI_TIMING_GEN -- requirements
Module: hdmi_timing_gen

---
 rtl/hdmi_timing_gen_pkg.sv | 56 +++++
 rtl/hdmi_timing_gen_timing_counter.sv | 25 ++
 rtl/hdmi_timing_gen.sv | 81 ++++++++
 tb/tb_hdmi_timing_gen.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_timing_gen_pkg.sv
// Shared video timing constants and mode encoding for the SD timing generator.
// One timing_t record describes a complete raster standard as counter thresholds.
package hdmi_timing_gen_pkg;

  localparam int CNT_W = 10;

  typedef enum logic [1:0] {
    MODE_NTSC = 2'd0,
    MODE_PAL  = 2'd1,
    MODE_MONO = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  localparam int H_ACTIVE_PX = 720;
  localparam logic [CNT_W-1:0] H_ACTIVE = CNT_W'(H_ACTIVE_PX);

  localparam int NTSC_H_FP = 16, NTSC_H_SYNC = 62, NTSC_H_BP = 60;
  localparam int NTSC_V_ACT = 480, NTSC_V_FP = 9, NTSC_V_SYNC = 6, NTSC_V_BP = 30;
  localparam int PAL_H_FP = 12, PAL_H_SYNC = 64, PAL_H_BP = 68;
  localparam int PAL_V_ACT = 576, PAL_V_FP = 5, PAL_V_SYNC = 5, PAL_V_BP = 39;

  // Sync windows are [start, end); *_last is the final count before wrap.
  typedef struct packed {
    logic [CNT_W-1:0] h_last;
    logic [CNT_W-1:0] h_sync_start;
    logic [CNT_W-1:0] h_sync_end;
    logic [CNT_W-1:0] v_last;
    logic [CNT_W-1:0] v_active;
    logic [CNT_W-1:0] v_sync_start;
    logic [CNT_W-1:0] v_sync_end;
  } timing_t;

  function automatic timing_t make_timing(input int h_fp, input int h_sync, input int h_bp,
                                          input int v_act, input int v_fp, input int v_sync,
                                          input int v_bp);
    timing_t t;
    t.h_sync_start = CNT_W'(H_ACTIVE_PX + h_fp);
    t.h_sync_end   = CNT_W'(H_ACTIVE_PX + h_fp + h_sync);
    t.h_last       = CNT_W'(H_ACTIVE_PX + h_fp + h_sync + h_bp - 1);
    t.v_active     = CNT_W'(v_act);
    t.v_sync_start = CNT_W'(v_act + v_fp);
    t.v_sync_end   = CNT_W'(v_act + v_fp + v_sync);
    t.v_last       = CNT_W'(v_act + v_fp + v_sync + v_bp - 1);
    return t;
  endfunction

  // Mono and the reserved code share PAL raster timing.
  function automatic timing_t timing_for(input mode_e m);
    if (m == MODE_NTSC)
      return make_timing(NTSC_H_FP, NTSC_H_SYNC, NTSC_H_BP,
                         NTSC_V_ACT, NTSC_V_FP, NTSC_V_SYNC, NTSC_V_BP);
    return make_timing(PAL_H_FP, PAL_H_SYNC, PAL_H_BP,
                       PAL_V_ACT, PAL_V_FP, PAL_V_SYNC, PAL_V_BP);
  endfunction

endpackage

// File: rtl/hdmi_timing_gen_timing_counter.sv
// Wrap counter with synchronous load; wraps to 0 on an enabled step at or past `last`,
// so a count left out of range by a timing change recovers on its next step.
module timing_counter #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] last,
  output logic [W-1:0] count,
  output logic         at_last
);

  assign at_last = (count >= last);

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset)        count <= '0;
    else if (load)    count <= load_val;
    else if (en)      count <= at_last ? '0 : count + 1'b1;
  end

endmodule

// File: rtl/hdmi_timing_gen.sv
// SD raster timing generator: h/v counters, latched timing set, registered sync/DE/coords.
// vreset resynchronises the counters to RESYNC_H/RESYNC_V and latches the requested mode.
module hdmi_timing_gen
  import hdmi_timing_gen_pkg::*;
#(
  parameter int unsigned RESYNC_H = 0,
  parameter int unsigned RESYNC_V = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic             vreset,
  output logic             hs,
  output logic             vs,
  output logic             de,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             sof,
  output logic             locked
);

  timing_t          timing_q;
  logic [CNT_W-1:0] h, v;
  logic             h_last, v_last, frame_wrap;
  logic             active, h_in_sync, v_in_sync;

  timing_counter #(.W(CNT_W)) u_h_cnt (
    .clk      (clk),
    .reset    (reset),
    .en       (1'b1),
    .load     (vreset),
    .load_val (CNT_W'(RESYNC_H)),
    .last     (timing_q.h_last),
    .count    (h),
    .at_last  (h_last)
  );

  timing_counter #(.W(CNT_W)) u_v_cnt (
    .clk      (clk),
    .reset    (reset),
    .en       (h_last),
    .load     (vreset),
    .load_val (CNT_W'(RESYNC_V)),
    .last     (timing_q.v_last),
    .count    (v),
    .at_last  (v_last)
  );

  assign frame_wrap = h_last && v_last;

  // Mode is only honoured at frame boundaries so a frame never mixes standards.
  always_ff @(posedge clk) begin
    if (reset)                     timing_q <= timing_for(MODE_PAL);
    else if (vreset || frame_wrap) timing_q <= timing_for(mode_e'(mode));
  end

  assign active    = (h < H_ACTIVE) && (v < timing_q.v_active);
  assign h_in_sync = (h >= timing_q.h_sync_start) && (h < timing_q.h_sync_end);
  assign v_in_sync = (v >= timing_q.v_sync_start) && (v < timing_q.v_sync_end);

  always_ff @(posedge clk) begin
    if (reset) begin
      hs     <= 1'b1;
      vs     <= 1'b1;
      de     <= 1'b0;
      x      <= '0;
      y      <= '0;
      sof    <= 1'b0;
      locked <= 1'b0;
    end else begin
      hs     <= ~h_in_sync;
      vs     <= ~v_in_sync;
      de     <= active;
      x      <= active ? h : '0;
      y      <= active ? v : '0;
      sof    <= (h == '0) && (v == '0);
      locked <= locked | vreset;
    end
  end

endmodule

// File: tb/tb_hdmi_timing_gen.sv
// Randomised bench for hdmi_timing_gen: a raster-position reference model feeds a scoreboard
// queue, an independent monitor compares every output cycle and gathers period statistics.
module tb_hdmi_timing_gen;

  // Resync line placed near the PAL frame end so frame wraps are reachable in a short run,
  // and beyond the NTSC frame so an NTSC resync lands out of range.
  localparam int RH = 0;
  localparam int RV = 583;

  logic       clk = 1'b0;
  logic       reset, vreset;
  logic [1:0] mode;
  logic       hs, vs, de, sof, locked;
  logic [9:0] x, y;

  hdmi_timing_gen #(.RESYNC_H(RH), .RESYNC_V(RV)) dut (
    .clk    (clk),
    .reset  (reset),
    .mode   (mode),
    .vreset (vreset),
    .hs     (hs),
    .vs     (vs),
    .de     (de),
    .x      (x),
    .y      (y),
    .sof    (sof),
    .locked (locked)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       hs, vs, de;
    logic [9:0] x, y;
    logic       sof, locked;
  } out_t;

  out_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  // Raster tables, index 0 = NTSC, 1 = PAL.
  int h_total [2] = '{858, 864};
  int h_fp    [2] = '{16, 12};
  int h_sync  [2] = '{62, 64};
  int v_total [2] = '{525, 625};
  int v_act   [2] = '{480, 576};
  int v_fp    [2] = '{9, 5};
  int v_sync  [2] = '{6, 5};

  // Model state: linear raster position within the frame, selected standard, lock flag.
  int pos = 0;
  int std_i = 1;
  bit lk = 1'b0;

  // Monitor statistics.
  int cyc = 0, last_fall = 0, hs_period = 0, de_run = 0, de_line = 0;
  int sof_cnt = 0, vs_low_cnt = 0;
  bit have_fall = 1'b0;
  logic prev_hs = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s @%0t: got %h, want %h", name, $time, act, req);
  endtask

  function automatic out_t model_out();
    out_t e;
    int col, line;
    bit act;
    col  = pos % h_total[std_i];
    line = pos / h_total[std_i];
    act  = (col < 720) && (line < v_act[std_i]);
    e.hs = !((col >= 720 + h_fp[std_i]) && (col < 720 + h_fp[std_i] + h_sync[std_i]));
    e.vs = !((line >= v_act[std_i] + v_fp[std_i]) &&
             (line < v_act[std_i] + v_fp[std_i] + v_sync[std_i]));
    e.de  = act;
    e.x   = act ? 10'(col) : 10'd0;
    e.y   = act ? 10'(line) : 10'd0;
    e.sof = (pos == 0);
    e.locked = lk;
    return e;
  endfunction

  function automatic int std_of(input logic [1:0] md);
    return (md == 2'd0) ? 0 : 1;
  endfunction

  // One clock of stimulus: expected outputs after this edge come from the pre-edge position.
  task automatic step(input bit rst, input bit vr, input logic [1:0] md);
    out_t e;
    reset  = rst;
    vreset = vr;
    mode   = md;
    if (rst) begin
      e = '{hs: 1'b1, vs: 1'b1, de: 1'b0, x: 10'd0, y: 10'd0, sof: 1'b0, locked: 1'b0};
      pos = 0; std_i = 1; lk = 1'b0;
    end else begin
      e = model_out();
      e.locked = lk | vr;
      if (vr) begin
        std_i = std_of(md);
        pos   = RV * h_total[std_i] + RH;
        lk    = 1'b1;
      end else begin
        pos++;
        // A new line starting at or beyond the frame size is the frame origin.
        if ((pos % h_total[std_i] == 0) && (pos >= h_total[std_i] * v_total[std_i])) begin
          pos   = 0;
          std_i = std_of(md);
        end
      end
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: one scoreboard comparison per output cycle, plus timing statistics.
  initial begin
    out_t e, a;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {hs, vs, de, x, y, sof, locked};
        check("outputs{hs,vs,de,x,y,sof,locked}", 32'(a), 32'(e));
        if (prev_hs === 1'b1 && hs === 1'b0) begin
          if (have_fall) hs_period = cyc - last_fall;
          last_fall = cyc;
          have_fall = 1'b1;
          de_line   = de_run;
          de_run    = 0;
        end
        prev_hs = hs;
        if (de === 1'b1)  de_run++;
        if (sof === 1'b1) sof_cnt++;
        if (vs === 1'b0)  vs_low_cnt++;
      end
    end
  end

  initial begin
    logic [1:0] md;
    int rem, sw, sz;

    // Reset, including reset and vreset together: reset wins, locked stays low.
    step(1'b1, 1'b0, 2'd1);
    step(1'b1, 1'b1, 2'd0);
    step(1'b1, 1'b0, 2'd1);

    // Free-running PAL with mid-frame mode noise that must be ignored.
    md = 2'd1;
    for (int i = 0; i < 2000; i++) begin
      if (i % 100 == 0) md = 2'($urandom_range(0, 3));
      step(1'b0, 1'b0, md);
    end
    check("pal hs period", 32'(hs_period), 32'd864);
    check("pal de per line", 32'(de_line), 32'd720);

    // Resync at column 400, then request NTSC partway through: PAL finishes the frame.
    for (int i = 0; i < 1000 && (pos % h_total[std_i]) != 400; i++) step(1'b0, 1'b0, 2'd1);
    step(1'b0, 1'b1, 2'd1);
    sof_cnt = 0;
    sz  = h_total[std_i] * v_total[std_i];
    rem = sz - pos;
    sw  = $urandom_range(1000, rem - 1000);
    for (int i = 0; i < rem; i++)
      step(1'b0, 1'b0, (i >= sw) ? 2'd0 : 2'($urandom_range(1, 3)));
    for (int i = 0; i < 2000; i++) step(1'b0, 1'b0, 2'd0);
    check("single sof at pal->ntsc wrap", 32'(sof_cnt), 32'd1);
    check("ntsc hs period", 32'(hs_period), 32'd858);
    check("ntsc de per line", 32'(de_line), 32'd720);

    // NTSC resync lands beyond the frame: v must fold to 0 at the line wrap, vs stays high.
    step(1'b0, 1'b1, 2'd0);
    sof_cnt = 0;
    vs_low_cnt = 0;
    for (int i = 0; i < 2000; i++) step(1'b0, 1'b0, 2'd0);
    check("out-of-range v folds to origin", 32'(sof_cnt), 32'd1);
    check("no vs glitch on fold", 32'(vs_low_cnt), 32'd0);
    check("ntsc hs period after fold", 32'(hs_period), 32'd858);

    // PAL resync, run through the vsync lines, then resync exactly on the frame wrap.
    step(1'b0, 1'b1, 2'($urandom_range(1, 3)));
    vs_low_cnt = 0;
    sz = h_total[std_i] * v_total[std_i];
    for (int i = 0; i < 40000 && pos != sz - 1; i++)
      step(1'b0, 1'b0, 2'($urandom_range(1, 3)));
    check("pal vs low cycles", 32'(vs_low_cnt), 32'd2592);
    sof_cnt = 0;
    step(1'b0, 1'b1, 2'($urandom_range(1, 3)));
    for (int i = 0; i < 2000; i++) step(1'b0, 1'b0, 2'd1);
    check("vreset beats wrap: no sof", 32'(sof_cnt), 32'd0);

    // Reset mid-frame together with vreset, then free-run PAL again.
    for (int i = 0; i < 50; i++) step(1'b0, 1'b0, 2'd1);
    step(1'b1, 1'b1, 2'd0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 2'd1);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
